// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit DCT words with a 4-bit atom count.
// A word closes when it is full, on flush or end-of-test, or after an idle timeout.
module nios2_oci_dct_packer #(
    parameter int unsigned IDLE_TIMEOUT = 64,
    parameter int unsigned DROP_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              atom_valid,
    input  logic [1:0]        atom,
    input  logic              flush,
    input  logic              test_ending,
    input  logic              test_has_ended,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [29:0]       dct_buffer,
    output logic [3:0]        dct_count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    localparam int unsigned TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO = TW'(IDLE_TIMEOUT);

    logic [29:0]       buf_q, buf_d, fill_buf;
    logic [3:0]        cnt_q, cnt_d, fill_cnt;
    logic [TW-1:0]     timer_q, timer_d, timer_inc;
    logic              out_valid_q, out_valid_d;
    logic [29:0]       out_buf_q, out_buf_d;
    logic [3:0]        out_cnt_q, out_cnt_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic out_free, acc, drop, idle_hit, close;

    always_comb begin
        out_free  = ~out_valid_q | out_ready;
        acc       = atom_valid & ~test_has_ended & out_free;
        drop      = atom_valid & ~test_has_ended & ~out_free;

        fill_buf = buf_q;
        for (int k = 0; k < 15; k++) begin
            if (acc && cnt_q == 4'(k)) fill_buf[2*k +: 2] = atom;
        end
        fill_cnt = cnt_q + {3'b000, acc};

        timer_inc = (timer_q == TMO) ? timer_q : timer_q + 1'b1;
        idle_hit  = (cnt_q != 4'd0) && !acc && (timer_inc == TMO);

        // A close that cannot fire now stays pending: its condition persists next cycle.
        close = out_free && (fill_cnt != 4'd0) &&
                ((fill_cnt == 4'd15) || flush || test_ending || idle_hit);

        buf_d       = fill_buf;
        cnt_d       = fill_cnt;
        timer_d     = '0;
        out_buf_d   = out_buf_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q & ~out_ready;

        if (close) begin
            out_buf_d   = fill_buf;
            out_cnt_d   = fill_cnt;
            out_valid_d = 1'b1;
            buf_d       = '0;
            cnt_d       = '0;
        end else if (!acc && cnt_q != 4'd0) begin
            timer_d = timer_inc;
        end

        ovf_d  = ovf_q | drop;
        drop_d = drop_q;
        if (drop && drop_q != '1) drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q       <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            out_valid_q <= 1'b0;
            out_buf_q   <= '0;
            out_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            out_valid_q <= out_valid_d;
            out_buf_q   <= out_buf_d;
            out_cnt_q   <= out_cnt_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign dct_buffer = out_buf_q;
    assign dct_count  = out_cnt_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Bench for nios2_oci_dct_packer: two instances (default and short-timeout/narrow-drop)
// checked every cycle against a word-level model, plus hand-computed literal checks.
module tb_nios2_oci_dct_packer;

    logic       clk;
    logic       reset;
    logic       atom_valid;
    logic [1:0] atom;
    logic       flush;
    logic       test_ending;
    logic       test_has_ended;
    logic       out_ready;

    logic        ov   [2];
    logic [29:0] db   [2];
    logic [3:0]  dcnt [2];
    logic        ovf  [2];
    logic [7:0]  dc0;
    logic [1:0]  dc1;

    int n_cmp = 0;
    int n_bad = 0;

    nios2_oci_dct_packer #(.IDLE_TIMEOUT(64), .DROP_W(8)) dut_a (
        .clk(clk), .reset(reset), .atom_valid(atom_valid), .atom(atom), .flush(flush),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .out_ready(out_ready),
        .out_valid(ov[0]), .dct_buffer(db[0]), .dct_count(dcnt[0]), .overflow(ovf[0]),
        .drop_count(dc0)
    );

    nios2_oci_dct_packer #(.IDLE_TIMEOUT(4), .DROP_W(2)) dut_b (
        .clk(clk), .reset(reset), .atom_valid(atom_valid), .atom(atom), .flush(flush),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .out_ready(out_ready),
        .out_valid(ov[1]), .dct_buffer(db[1]), .dct_count(dcnt[1]), .overflow(ovf[1]),
        .drop_count(dc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-level model: list of pending atoms, idle-cycle count, one held word.
    int     tmo  [2] = '{64, 4};
    int     dmax [2] = '{255, 3};
    int     mn   [2];
    int     midle[2];
    int     slots[2][16];
    bit     mv   [2];
    longint mbuf [2];
    int     mcnt [2];
    bit     movf [2];
    int     mdrop[2];

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d got=%0h expected=%0h t=%0t", name, idx, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] drop_of(input int i);
        return (i == 0) ? {24'd0, dc0} : {30'd0, dc1};
    endfunction

    task automatic model_step(input int i);
        bit fr;
        bit accepted;
        if (reset) begin
            mn[i] = 0; midle[i] = 0; mv[i] = 0; mbuf[i] = 0; mcnt[i] = 0;
            movf[i] = 0; mdrop[i] = 0;
            return;
        end
        fr = !mv[i] || out_ready;
        accepted = 0;
        if (atom_valid && !test_has_ended) begin
            if (fr) begin
                slots[i][mn[i]] = int'(atom);
                mn[i]++;
                midle[i] = 0;
                accepted = 1;
            end else begin
                movf[i] = 1;
                if (mdrop[i] < dmax[i]) mdrop[i]++;
            end
        end
        if (!accepted && mn[i] > 0 && midle[i] < tmo[i]) midle[i]++;
        if (fr && mn[i] > 0 &&
            (mn[i] == 15 || flush || test_ending || midle[i] >= tmo[i])) begin
            mbuf[i] = 0;
            for (int k = 0; k < mn[i]; k++) mbuf[i] += longint'(slots[i][k]) << (2 * k);
            mcnt[i]  = mn[i];
            mv[i]    = 1;
            mn[i]    = 0;
            midle[i] = 0;
        end else if (mv[i] && out_ready) begin
            mv[i] = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            mn[i] = 0; midle[i] = 0; mv[i] = 0; mbuf[i] = 0; mcnt[i] = 0;
            movf[i] = 0; mdrop[i] = 0;
        end
    end

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("cmp_out_valid", i, {31'd0, ov[i]}, {31'd0, mv[i]});
            if (mv[i]) begin
                chk("cmp_dct_buffer", i, {2'd0, db[i]}, 32'(mbuf[i]));
                chk("cmp_dct_count", i, {28'd0, dcnt[i]}, 32'(mcnt[i]));
            end
            chk("cmp_overflow", i, {31'd0, ovf[i]}, {31'd0, movf[i]});
            chk("cmp_drop_count", i, drop_of(i), 32'(mdrop[i]));
        end
    end

    task automatic step(input logic v, input logic [1:0] a, input logic f, input logic te,
                        input logic th, input logic r);
        atom_valid = v; atom = a; flush = f; test_ending = te; test_has_ended = th;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic lit_zero(input int i);
        chk("lit_zero_out_valid", i, {31'd0, ov[i]}, 32'd0);
        chk("lit_zero_dct_buffer", i, {2'd0, db[i]}, 32'd0);
        chk("lit_zero_dct_count", i, {28'd0, dcnt[i]}, 32'd0);
        chk("lit_zero_overflow", i, {31'd0, ovf[i]}, 32'd0);
        chk("lit_zero_drop_count", i, drop_of(i), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        step(0, 2'd0, 0, 0, 0, 1);
        step(0, 2'd0, 0, 0, 0, 1);
        reset = 1'b0;
        lit_zero(0);
        lit_zero(1);

        // 15 atoms of 01 close a full word
        for (int k = 0; k < 15; k++) step(1, 2'd1, 0, 0, 0, 1);
        chk("lit_full_valid", 0, {31'd0, ov[0]}, 32'd1);
        chk("lit_full_count", 0, {28'd0, dcnt[0]}, 32'd15);
        chk("lit_full_buffer", 0, {2'd0, db[0]}, 32'h15555555);
        chk("lit_full_drops", 0, drop_of(0), 32'd0);
        step(0, 2'd0, 0, 0, 0, 1);
        chk("lit_full_xfer", 0, {31'd0, ov[0]}, 32'd0);

        // 3, 2, 1 then flush
        step(1, 2'd3, 0, 0, 0, 1);
        step(1, 2'd2, 0, 0, 0, 1);
        step(1, 2'd1, 0, 0, 0, 1);
        step(0, 2'd0, 1, 0, 0, 1);
        chk("lit_flush_count", 0, {28'd0, dcnt[0]}, 32'd3);
        chk("lit_flush_buffer", 0, {2'd0, db[0]}, 32'h1B);
        step(0, 2'd0, 1, 0, 0, 1);
        chk("lit_empty_flush", 0, {31'd0, ov[0]}, 32'd0);
        step(0, 2'd0, 1, 0, 0, 1);
        chk("lit_empty_flush2", 0, {31'd0, ov[0]}, 32'd0);

        // Idle timeout on dut_b (4)
        step(1, 2'd3, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 2'd0, 0, 0, 0, 1);
        chk("lit_idle_early", 1, {31'd0, ov[1]}, 32'd0);
        step(0, 2'd0, 0, 0, 0, 1);
        chk("lit_idle_valid", 1, {31'd0, ov[1]}, 32'd1);
        chk("lit_idle_count", 1, {28'd0, dcnt[1]}, 32'd1);
        chk("lit_idle_buffer", 1, {2'd0, db[1]}, 32'h3);
        for (int k = 0; k < 6; k++) step(0, 2'd0, 0, 0, 0, 1);
        chk("lit_idle_nomore", 1, {31'd0, ov[1]}, 32'd0);
        step(0, 2'd0, 1, 0, 0, 1);
        step(0, 2'd0, 0, 0, 0, 1);

        // Hold a full word, drop 20 atoms
        for (int k = 0; k < 15; k++) step(1, 2'(k % 4), 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) step(1, 2'd1, 0, 0, 0, 0);
        chk("lit_hold_valid", 0, {31'd0, ov[0]}, 32'd1);
        chk("lit_hold_buffer", 0, {2'd0, db[0]}, 32'h24E4E4E4);
        chk("lit_hold_overflow", 0, {31'd0, ovf[0]}, 32'd1);
        chk("lit_hold_drops", 0, drop_of(0), 32'd20);
        chk("lit_sat_drops", 1, drop_of(1), 32'd3);
        step(1, 2'd2, 0, 0, 0, 1);
        chk("lit_xfer_accept", 0, {31'd0, ov[0]}, 32'd0);
        step(0, 2'd0, 1, 0, 0, 1);
        chk("lit_slot0_count", 0, {28'd0, dcnt[0]}, 32'd1);
        chk("lit_slot0_buffer", 0, {2'd0, db[0]}, 32'h2);
        step(0, 2'd0, 0, 0, 0, 1);

        // test_ending with 7 atoms, then atoms ignored
        for (int k = 0; k < 7; k++) step(1, 2'd3, 0, 0, 0, 1);
        step(0, 2'd0, 0, 1, 0, 1);
        chk("lit_te_count", 0, {28'd0, dcnt[0]}, 32'd7);
        chk("lit_te_buffer", 0, {2'd0, db[0]}, 32'h3FFF);
        for (int k = 0; k < 10; k++) step(1, 2'd2, 0, 0, 1, 0);
        step(1, 2'd2, 0, 0, 1, 1);
        for (int k = 0; k < 5; k++) step(1, 2'd2, 0, 0, 1, 1);
        chk("lit_ended_valid", 0, {31'd0, ov[0]}, 32'd0);
        chk("lit_ended_drops", 0, drop_of(0), 32'd20);

        // Random traffic, checked by the model only
        for (int k = 0; k < 300; k++) begin
            step(($urandom % 4) != 0, 2'($urandom), ($urandom % 16) == 0, 1'b0,
                 ($urandom % 32) == 0, ($urandom % 3) != 0);
        end

        // Drain, hold a word, then reset mid-traffic
        step(0, 2'd0, 1, 0, 0, 1);
        step(0, 2'd0, 0, 0, 0, 1);
        step(0, 2'd0, 0, 0, 0, 1);
        for (int k = 0; k < 18; k++) step(1, 2'd1, 0, 0, 0, 0);
        reset = 1'b1;
        step(1, 2'd1, 0, 0, 0, 0);
        reset = 1'b0;
        lit_zero(0);
        lit_zero(1);
        for (int k = 0; k < 3; k++) step(0, 2'd0, 0, 0, 0, 1);
        chk("lit_post_reset", 0, {31'd0, ov[0]}, 32'd0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nios2_oci_dct_packer.md
# nios2_oci_dct_packer

Packs the 2-bit trace atoms produced by the Nios II on-chip instrumentation into 30-bit data-capture-trace (DCT) words and schedules their hand-off to the downstream trace store. Each word carries a 4-bit atom count. The block decides when a word is closed: when it is full, on an explicit flush, on end-of-test, or after an idle timeout. Trace sources cannot be stalled, so atoms that arrive while no slot is free are dropped and counted.

## Interface
- IDLE_TIMEOUT, 64: cycles without an accepted atom after which a partial word is closed; range 2..65535.
- DROP_W, 8: width of the saturating drop counter.
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- atom_valid  in  1  a trace atom is present this cycle.
- atom  in  2  trace atom value.
- flush  in  1  close the current partial word.
- test_ending  in  1  end-of-test request; behaves as flush.
- test_has_ended  in  1  trace is over; ignore all further atoms.
- out_ready  in  1  downstream accepts the word.
- out_valid  out  1  dct_buffer/dct_count hold a closed word.
- dct_buffer  out  30  packed atoms; atom k is at bits [2k+1:2k], k=0 is the oldest.
- dct_count  out  4  number of valid atoms in dct_buffer, 1..15 while out_valid.
- overflow  out  1  sticky; set by the first dropped atom.
- drop_count  out  DROP_W  dropped atoms, saturating at all-ones.

## Operation
- Internal state: fill buffer `buf[29:0]`, `cnt[3:0]`, idle timer, and an output register pair with `out_valid`.
- Control states:
  - EMPTY: `cnt`=0.
  - FILL: 0<`cnt`<15.
  - HOLD: `out_valid`=1, word waiting for `out_ready`.
- A transfer occurs on a cycle with `out_valid` and `out_ready` both high.
- Atom acceptance:
  - `acc = atom_valid & ~test_has_ended & (~out_valid | out_ready)`.
  - An accepted atom is written to slot `cnt` and `cnt` increments.
  - Unused upper bits of the buffer are 0.
- Drop:
  - `atom_valid & ~test_has_ended & out_valid & ~out_ready` drops the atom.
  - It sets `overflow` and increments `drop_count`, saturating.
  - Atoms arriving while `test_has_ended` is high are neither accepted nor counted.
- Close conditions, evaluated after the acceptance of this cycle's atom:
  - the new `cnt` equals 15, or
  - `flush` or `test_ending` is high and the new `cnt` is greater than 0, or
  - the idle timer reaches IDLE_TIMEOUT with `cnt`>0.
- On close:
  - The buffer and count move to the output registers and `out_valid` is set.
  - The fill buffer and `cnt` clear to 0 on the same edge.
- Close is allowed only when the output register is free or is transferring this cycle. Otherwise the close is held pending:
  - a pending full (15) or flush close retries every cycle;
  - an atom that would make the count 16 cannot occur, because acceptance is blocked while in HOLD without `out_ready`.
- Flush or `test_ending` with `cnt`=0 has no effect; no empty words are ever emitted.
- Idle timer:
  - clears on each accepted atom and on close;
  - counts only while `cnt`>0;
  - saturates at IDLE_TIMEOUT.

## Timing
- Reset values:
  - `out_valid`=0, `dct_buffer`=0, `dct_count`=0, `overflow`=0, `drop_count`=0;
  - fill buffer, `cnt` and idle timer = 0.
- Reset mid-word discards the partial word and any held word without emitting them.
- Latency: `out_valid` rises on the edge that accepts the 15th atom, so it is visible the next cycle. Flush close behaves the same way: one cycle after the flush is sampled.
- `out_valid`, `dct_buffer` and `dct_count` stay stable until the transfer cycle, and `out_valid` does not drop without a transfer.
- Back-to-back operation: in a transfer cycle an atom is accepted into slot 0 of the empty fill buffer. A 15-atom close may coincide with a transfer, in which case the new word replaces the old one on the same edge with `out_valid` staying 1.
- Sustained throughput is 1 atom/cycle with `out_ready` held high, with no drops.

## Test plan
- Reset, then 15 consecutive atoms of 2'b01, `out_ready`=1 → one cycle after the 15th atom: `out_valid`=1, `dct_count`=15, `dct_buffer`=30'h15555555, no drops.
- Atoms 3, 2, 1, then `flush` → next cycle: `dct_count`=3, `dct_buffer`=30'h0000001B. A second `flush` with the buffer empty → no word.
- IDLE_TIMEOUT=4, a single atom 2'b11 followed by silence → word with `dct_count`=1 and `dct_buffer`=30'h3, emitted 4 cycles after the timer starts counting; no further words.
- `out_ready`=0 while holding a full word, then 20 more atoms → `out_valid` held with the word unchanged, `overflow`=1, `drop_count`=20. Raising `out_ready` → transfer, and the atom of that cycle lands in slot 0.
- DROP_W=2 with 5 drops → `drop_count` saturates at 3.
- `test_ending` with 7 atoms pending, then `test_has_ended` high with further atoms → one word with `dct_count`=7, no drops counted, nothing further emitted. Reset asserted mid-word → all outputs return to 0.
